// File: rtl/key_encoder_if.sv
// Key encoder port bundle: enable qualifiers, raw key levels and encoded event outputs.
// Latency: none (signal container only).
// Backpressure: none; the consumer must accept o_key_valid pulses as they come.
interface key_encoder_if;
    logic       sw_2;
    logic       sw_3;
    logic [8:0] i_key;
    logic [3:0] o_key_data;
    logic       o_key_valid;

    // Stimulus / consumer side
    modport master (
        output sw_2,
        output sw_3,
        output i_key,
        input  o_key_data,
        input  o_key_valid
    );

    // Encoder side
    modport slave (
        input  sw_2,
        input  sw_3,
        input  i_key,
        output o_key_data,
        output o_key_valid
    );
endinterface

// File: rtl/key_encoder.sv
// Purpose: debounce a 9-key pad and encode single presses into codes 1..9 with a one-clk event strobe.
// Latency: 2 sync clks + DEB_SAMPLES ticks + 1 tick (max) from stable press to o_key_valid.
// Backpressure: none; events are single-clk pulses. Optional macro KEY_AUTOREPEAT_EN adds held-key auto-repeat.
module key_encoder #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SAMPLE_HZ   = 1_000,
    parameter int DEB_SAMPLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    key_encoder_if.slave  bus
);

    localparam int DIV = (CLK_HZ / SAMPLE_HZ > 0) ? (CLK_HZ / SAMPLE_HZ) : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [9:0] RPT_FIRST  = 10'd500;
    localparam logic [9:0] RPT_PERIOD = 10'd100;
`endif

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESSED      = 2'd1,
        ST_RELEASE_WAIT = 2'd2
    } state_t;

    logic          en;
    logic [CW-1:0] tick_cnt;
    logic          tick;

    logic [8:0]    sync1;
    logic [8:0]    sync2;

    // Only the previous DEB_SAMPLES-1 samples are stored; together with the
    // sample taken this tick they form the full DEB_SAMPLES-wide window.
    logic [DEB_SAMPLES-2:0] hist    [9];
    logic [DEB_SAMPLES-1:0] hist_nx [9];
    logic [8:0]             deb;
    logic [8:0]             deb_nx;

    logic [3:0]    ones;
    logic [3:0]    key_code;
    logic          is_none;
    logic          is_single;
    logic          is_multi;

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    data_q;
    logic [3:0]    data_d;
    logic          valid_q;
    logic          valid_d;

`ifdef KEY_AUTOREPEAT_EN
    logic [9:0]    rpt_cnt;
    logic [9:0]    rpt_cnt_d;
    logic          rpt_first;
    logic          rpt_first_d;
`endif

    assign en = bus.sw_2 & bus.sw_3;

    // Sample-rate divider; parked at zero whenever the block is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (!en || tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = en && (tick_cnt == TICK_LAST);

    // Two-flop synchronizer on every raw key line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.i_key;
            sync2 <= sync1;
        end
    end

    // Next sample window and debounced level: a key flips only when the whole window agrees.
    always_comb begin
        deb_nx = deb;
        for (int n = 0; n < 9; n++) begin
            hist_nx[n] = {hist[n], sync2[n]};
            if (&hist_nx[n]) begin
                deb_nx[n] = 1'b1;
            end else if (~|hist_nx[n]) begin
                deb_nx[n] = 1'b0;
            end
        end
    end

    // Debounce state advances on ticks and is wiped when the block is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 9; n++) begin
                hist[n] <= '0;
            end
            deb <= '0;
        end else if (!en) begin
            for (int n = 0; n < 9; n++) begin
                hist[n] <= '0;
            end
            deb <= '0;
        end else if (tick) begin
            for (int n = 0; n < 9; n++) begin
                hist[n] <= hist_nx[n][DEB_SAMPLES-2:0];
            end
            deb <= deb_nx;
        end
    end

    // Classify the debounced vector: none, single key (with its code) or chord.
    always_comb begin
        ones     = '0;
        key_code = '0;
        for (int i = 0; i < 9; i++) begin
            if (deb[i]) begin
                ones     = ones + 4'd1;
                key_code = 4'(i + 1);
            end
        end
        is_none   = (ones == 4'd0);
        is_single = (ones == 4'd1);
        is_multi  = (ones >= 4'd2);
    end

    // FSM and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt   <= rpt_cnt_d;
            rpt_first <= rpt_first_d;
`endif
        end
    end

    // Next-state and event logic; transitions are only evaluated on tick cycles.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rpt_cnt_d   = rpt_cnt;
        rpt_first_d = rpt_first;
`endif
        if (!en) begin
            state_d = ST_IDLE;
            data_d  = '0;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_single) begin
                        state_d = ST_PRESSED;
                        data_d  = key_code;
                        valid_d = 1'b1;
                    end else if (is_multi) begin
                        // Ambiguous chord: swallow it until everything is released.
                        state_d = ST_RELEASE_WAIT;
                    end
                end
                ST_PRESSED: begin
                    if (is_none) begin
                        state_d = ST_IDLE;
                    end else if (is_multi || key_code != data_q) begin
                        state_d = ST_RELEASE_WAIT;
                    end else begin
`ifdef KEY_AUTOREPEAT_EN
                        rpt_cnt_d = rpt_cnt + 10'd1;
                        if (rpt_cnt_d == (rpt_first ? RPT_FIRST : RPT_PERIOD)) begin
                            valid_d     = 1'b1;
                            rpt_cnt_d   = '0;
                            rpt_first_d = 1'b0;
                        end
`else
                        state_d = ST_PRESSED;
`endif
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (is_none) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
`ifdef KEY_AUTOREPEAT_EN
        // Repeat timing restarts from scratch on every new press.
        if (state_d != ST_PRESSED) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end
`endif
    end

    assign bus.o_key_data  = data_q;
    assign bus.o_key_valid = valid_q;

endmodule

// File: tb/tb_key_encoder.sv
// Directed bench for key_encoder with a fast sample tick (10 clks per tick).
// Latency: checks are placed at fixed tick offsets after each stimulus step.
// Backpressure: not applicable; every o_key_valid pulse is counted by a monitor.
`timescale 1ns/1ps
module tb_key_encoder;

    localparam int CLK_HZ    = 10_000;
    localparam int SAMPLE_HZ = 1_000;
    localparam int DEB       = 4;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;

    logic clk;
    logic rst;

    key_encoder_if kif ();

    key_encoder #(
        .CLK_HZ      (CLK_HZ),
        .SAMPLE_HZ   (SAMPLE_HZ),
        .DEB_SAMPLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Event monitor: counts pulses, remembers the code, flags back-to-back pulses.
    int         ev_cnt   = 0;
    logic [3:0] last_code = 4'd0;
    logic       prev_vld = 1'b0;
    logic       dbl_seen = 1'b0;

    always @(negedge clk) begin
        if (kif.o_key_valid === 1'b1) begin
            ev_cnt    = ev_cnt + 1;
            last_code = kif.o_key_data;
            if (prev_vld) dbl_seen = 1'b1;
        end
        prev_vld = (kif.o_key_valid === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n sample ticks worth of clocks, landing 2ns after a rising edge.
    task automatic ticks(input int n);
        repeat (n * DIV) @(posedge clk);
        #2;
    endtask

    int base;

    initial begin
        rst       = 1'b1;
        kif.sw_2  = 1'b0;
        kif.sw_3  = 1'b0;
        kif.i_key = 9'd0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_data", 32'(kif.o_key_data), 32'd0);
        check("rst_valid", 32'(kif.o_key_valid), 32'd0);

        rst      = 1'b0;
        kif.sw_2 = 1'b1;
        kif.sw_3 = 1'b1;
        ticks(6);
        check("idle_no_event", 32'(ev_cnt), 32'd0);

        // Single key 3 held for 10 ms; boundary: no event before DEB samples exist.
        base      = ev_cnt;
        kif.i_key = 9'b000000100;
        ticks(3);
        check("k3_too_early", 32'(ev_cnt - base), 32'd0);
        ticks(7);
        check("k3_count", 32'(ev_cnt - base), 32'd1);
        check("k3_code", 32'(last_code), 32'd3);
        check("k3_data", 32'(kif.o_key_data), 32'd3);
        kif.i_key = 9'd0;
        ticks(10);
        check("k3_release_count", 32'(ev_cnt - base), 32'd1);
        check("k3_data_retained", 32'(kif.o_key_data), 32'd3);

        // Bounce on key 1: toggling every 4 clks never yields DEB equal samples.
        base = ev_cnt;
        for (int i = 0; i < 8; i++) begin
            kif.i_key[0] = ~kif.i_key[0];
            repeat (4) @(posedge clk);
            #2;
        end
        check("bounce_no_event", 32'(ev_cnt - base), 32'd0);
        kif.i_key = 9'b000000001;
        ticks(10);
        check("bounce_settled_count", 32'(ev_cnt - base), 32'd1);
        check("bounce_settled_code", 32'(last_code), 32'd1);
        kif.i_key = 9'd0;
        ticks(10);

        // Key 2, then chord with key 5, release all, then key 5 alone.
        base      = ev_cnt;
        kif.i_key = 9'b000000010;
        ticks(10);
        check("k2_count", 32'(ev_cnt - base), 32'd1);
        check("k2_code", 32'(last_code), 32'd2);
        kif.i_key = 9'b000010010;
        ticks(10);
        check("chord_no_event", 32'(ev_cnt - base), 32'd1);
        check("chord_data_kept", 32'(kif.o_key_data), 32'd2);
        kif.i_key = 9'd0;
        ticks(10);
        check("chord_release_no_event", 32'(ev_cnt - base), 32'd1);
        kif.i_key = 9'b000010000;
        ticks(10);
        check("k5_count", 32'(ev_cnt - base), 32'd2);
        check("k5_code", 32'(last_code), 32'd5);
        kif.i_key = 9'd0;
        ticks(10);

        // Key 9 held while disabled, then enabled.
        base      = ev_cnt;
        kif.sw_3  = 1'b0;
        kif.i_key = 9'b100000000;
        @(posedge clk);
        #2;
        check("dis_data_cleared", 32'(kif.o_key_data), 32'd0);
        ticks(10);
        check("dis_no_event", 32'(ev_cnt - base), 32'd0);
        check("dis_data_zero", 32'(kif.o_key_data), 32'd0);
        kif.sw_3 = 1'b1;
        ticks(10);
        check("en_k9_count", 32'(ev_cnt - base), 32'd1);
        check("en_k9_code", 32'(last_code), 32'd9);
        kif.i_key = 9'd0;
        ticks(10);

        // Reset while key 4 is held; a fresh event follows release of reset.
        base      = ev_cnt;
        kif.i_key = 9'b000001000;
        ticks(10);
        check("k4_count", 32'(ev_cnt - base), 32'd1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("k4_rst_data", 32'(kif.o_key_data), 32'd0);
        check("k4_rst_valid", 32'(kif.o_key_valid), 32'd0);
        rst = 1'b0;
        ticks(3);
        check("k4_post_rst_early", 32'(ev_cnt - base), 32'd1);
        ticks(7);
        check("k4_post_rst_count", 32'(ev_cnt - base), 32'd2);
        check("k4_post_rst_code", 32'(last_code), 32'd4);
        kif.i_key = 9'd0;
        ticks(10);

`ifdef KEY_AUTOREPEAT_EN
        // Key 7 held for 1000 ticks: press, +500, then every 100 ticks.
        base      = ev_cnt;
        kif.i_key = 9'b001000000;
        ticks(1000);
        check("rpt_k7_count", 32'(ev_cnt - base), 32'd6);
        check("rpt_k7_code", 32'(last_code), 32'd7);
        kif.i_key = 9'd0;
        ticks(10);
`endif

        check("no_back_to_back_valid", 32'(dbl_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
